// File: rtl/icache_sync_nway.sv
// N-way set-associative I-cache: hit response 2 cycles after accept, miss response the cycle after the L2 beat, per-set round-robin victim.
// Build with ICACHE_PERF_CNT_EN defined to get saturating hit/miss counters; otherwise o_hit_cnt/o_miss_cnt are tied to 0.
module icache_sync_nway #(
  parameter int PA_W       = 34,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 128,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [PA_W-1:0]         i_req_pa,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [LINE_BYTES*8-1:0] o_resp_data,
  output logic                    o_l2_req_valid,
  input  logic                    i_l2_req_ready,
  output logic [PA_W-1:0]         o_l2_req_addr,
  input  logic                    i_l2_resp_valid,
  input  logic [LINE_BYTES*8-1:0] i_l2_resp_data,
  input  logic                    i_inv_all,
  output logic [31:0]             o_hit_cnt,
  output logic [31:0]             o_miss_cnt
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PA_W - IDX_W - OFF_W;
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int LA_W   = PA_W - OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [LA_W-1:0]     r_line;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]   r_data  [SETS][WAYS];
  logic [RR_W-1:0]     r_rr    [SETS];
  logic                r_inv_pending;
  logic [LINE_W-1:0]   r_resp_data;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit;
  logic [RR_W-1:0]     w_hit_way;
  logic [RR_W-1:0]     w_victim;
  logic                w_victim_inv;
  logic                w_flush;
  logic                w_refill;
  logic                w_unused_off;

  assign w_idx         = r_line[IDX_W-1:0];
  assign w_tag         = r_line[LA_W-1:IDX_W];
  assign w_refill      = !rst && (r_state == S_REFILL) && i_l2_resp_valid;
  assign w_unused_off  = ^i_req_pa[OFF_W-1:0];
  assign o_l2_req_addr = {r_line, {OFF_W{1'b0}}};
  assign o_resp_data   = r_resp_data;

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    w_hit_vec    = '0;
    w_hit_way    = '0;
    w_victim     = r_rr[w_idx];
    w_victim_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = RR_W'(w);
      if (!r_valid[w_idx][w]) begin
        w_victim     = RR_W'(w);
        w_victim_inv = 1'b1;
      end
    end
    w_hit = |w_hit_vec;
  end

  always_comb begin
    w_next         = r_state;
    w_flush        = 1'b0;
    o_req_ready    = 1'b0;
    o_l2_req_valid = 1'b0;
    o_resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_flush     = i_inv_all || r_inv_pending;
        o_req_ready = !w_flush;
        if (i_req_valid && !w_flush) w_next = S_LOOKUP;
      end
      S_LOOKUP:   w_next = w_hit ? S_RESP : S_MISS_REQ;
      S_MISS_REQ: begin
        o_l2_req_valid = 1'b1;
        if (i_l2_req_ready) w_next = S_REFILL;
      end
      S_REFILL:   if (i_l2_resp_valid) w_next = S_RESP;
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
    if (rst) begin
      w_flush        = 1'b0;
      o_req_ready    = 1'b0;
      o_l2_req_valid = 1'b0;
      o_resp_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A flush requested mid-transaction is deferred to the next IDLE cycle, so it also kills that refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line        <= '0;
      r_inv_pending <= 1'b0;
      r_resp_data   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (o_req_ready && i_req_valid) r_line <= i_req_pa[PA_W-1:OFF_W];
      if (w_flush) begin
        r_inv_pending <= 1'b0;
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end else if (i_inv_all) begin
        r_inv_pending <= 1'b1;
      end
      if (r_state == S_LOOKUP && w_hit) r_resp_data <= r_data[w_idx][w_hit_way];
      if (w_refill) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        r_resp_data              <= i_l2_resp_data;
        if (!w_victim_inv) r_rr[w_idx] <= (WAYS == 1) ? '0 : r_rr[w_idx] + RR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_data[w_idx][w_victim] <= i_l2_resp_data;
      r_tag[w_idx][w_victim]  <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_LOOKUP) assert ($onehot0(w_hit_vec));
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && r_hit_cnt != '1)    r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_hit && r_miss_cnt != '1)  r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`else
  assign o_hit_cnt  = '0;
  assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_sync_nway.sv
// Directed bench for icache_sync_nway; expected lines are queued at request time and popped when a response appears.
module tb_icache_sync_nway;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, o_req_ready;
  logic [33:0]   i_req_pa;
  logic          o_resp_valid, i_resp_ready;
  logic [LW-1:0] o_resp_data;
  logic          o_l2_req_valid, i_l2_req_ready;
  logic [33:0]   o_l2_req_addr;
  logic          i_l2_resp_valid;
  logic [LW-1:0] i_l2_resp_data;
  logic          i_inv_all;
  logic [31:0]   o_hit_cnt, o_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [LW-1:0] exp_q [$];

  always #5 clk = ~clk;

  icache_sync_nway dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_pa(i_req_pa),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_data(o_resp_data),
    .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready), .o_l2_req_addr(o_l2_req_addr),
    .i_l2_resp_valid(i_l2_resp_valid), .i_l2_resp_data(i_l2_resp_data),
    .i_inv_all(i_inv_all), .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
  );

  function automatic logic [LW-1:0] mk(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [31:0] cnt_model(input int v);
    logic [31:0] r;
    r = 32'(v);
`ifndef ICACHE_PERF_CNT_EN
    r = '0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt();
    check("hit_cnt", LW'(o_hit_cnt), LW'(cnt_model(exp_hit)));
    check("miss_cnt", LW'(o_miss_cnt), LW'(cnt_model(exp_miss)));
  endtask

  task automatic do_req(input logic [33:0] pa);
    int k;
    i_req_pa    = pa;
    i_req_valid = 1'b1;
    #1;
    k = 0;
    while (!o_req_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!o_req_ready) begin
      check("req_accept_timeout", LW'(o_req_ready), LW'(1));
      i_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic serve_miss(input logic [33:0] addr, input logic [LW-1:0] line, input int l2_stall, input bit inv);
    int k;
    k = 0;
    while (!o_l2_req_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("l2_req_valid", LW'(o_l2_req_valid), LW'(1));
    check("l2_req_addr", LW'(o_l2_req_addr), LW'(addr));
    if (l2_stall > 0) begin
      i_req_pa    = 34'h3_FFFF_FFE0;
      i_req_valid = 1'b1;
    end
    for (int c = 0; c < l2_stall; c++) begin
      @(negedge clk);
      check("l2_addr_stable", LW'(o_l2_req_addr), LW'(addr));
      check("l2_valid_held", LW'(o_l2_req_valid), LW'(1));
      check("no_accept_in_miss", LW'(o_req_ready), LW'(0));
    end
    i_req_valid    = 1'b0;
    i_l2_req_ready = 1'b1;
    @(negedge clk);
    i_l2_req_ready = 1'b0;
    check("l2_req_dropped", LW'(o_l2_req_valid), LW'(0));
    if (inv) begin
      i_inv_all = 1'b1;
      @(negedge clk);
      i_inv_all = 1'b0;
    end
    i_l2_resp_data  = line;
    i_l2_resp_valid = 1'b1;
    @(negedge clk);
    i_l2_resp_valid = 1'b0;
    i_l2_resp_data  = '0;
    check("miss_resp_latency", LW'(o_resp_valid), LW'(1));
  endtask

  task automatic get_resp(input int stall);
    int k;
    logic [LW-1:0] exp;
    k = 0;
    while (!o_resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("resp_valid", LW'(o_resp_valid), LW'(1));
    check("scoreboard_nonempty", LW'(exp_q.size() != 0), LW'(1));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if (stall > 0) begin
      i_req_pa    = 34'h3_FFFF_FFE0;
      i_req_valid = 1'b1;
    end
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check("resp_data_stable", o_resp_data, exp);
      check("resp_valid_held", LW'(o_resp_valid), LW'(1));
      check("no_accept_in_resp", LW'(o_req_ready), LW'(0));
    end
    i_req_valid = 1'b0;
    check("resp_data", o_resp_data, exp);
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    check("resp_released", LW'(o_resp_valid), LW'(0));
  endtask

  task automatic miss_req(input logic [33:0] pa, input logic [LW-1:0] line,
                          input int l2_stall, input int resp_stall, input bit inv);
    exp_q.push_back(line);
    do_req(pa);
    serve_miss(pa & ~34'h1F, line, l2_stall, inv);
    get_resp(resp_stall);
    exp_miss++;
  endtask

  task automatic hit_req(input logic [33:0] pa, input logic [LW-1:0] line);
    exp_q.push_back(line);
    do_req(pa);
    check("hit_lookup_no_resp", LW'(o_resp_valid), LW'(0));
    @(negedge clk);
    check("hit_latency", LW'(o_resp_valid), LW'(1));
    check("hit_no_l2", LW'(o_l2_req_valid), LW'(0));
    get_resp(0);
    exp_hit++;
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_pa = '0; i_resp_ready = 1'b0;
    i_l2_req_ready = 1'b0; i_l2_resp_valid = 1'b0; i_l2_resp_data = '0; i_inv_all = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", LW'(o_req_ready), LW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", LW'(o_req_ready), LW'(1));
    check("idle_resp_valid", LW'(o_resp_valid), LW'(0));
    check("idle_l2_valid", LW'(o_l2_req_valid), LW'(0));
    check("idle_resp_data", o_resp_data, LW'(0));
    check("idle_l2_addr", LW'(o_l2_req_addr), LW'(0));
    check_cnt();

    // cold miss, then hits on the same line including the max-offset alias
    miss_req(34'h0_0000_1040, mk(8'hA5), 0, 0, 1'b0);
    check_cnt();
    hit_req(34'h0_0000_1040, mk(8'hA5));
    hit_req(34'h0_0000_105F, mk(8'hA5));
    check_cnt();

    // three tags into set 2: the third evicts way0 (0x1040)
    miss_req(34'h0_0000_5040, mk(8'h5A), 0, 0, 1'b0);
    miss_req(34'h0_0000_9040, mk(8'h99), 0, 0, 1'b0);
    hit_req(34'h0_0000_5040, mk(8'h5A));
    hit_req(34'h0_0000_9040, mk(8'h99));
    // 0x1040 must miss again, exercised under L2 and IFU backpressure
    miss_req(34'h0_0000_1040, mk(8'hC3), 5, 4, 1'b0);
    check_cnt();

    // flush during refill: current response still returns refill data, later access misses
    miss_req(34'h0_0000_2060, mk(8'h26), 0, 0, 1'b1);
    check("pending_flush_blocks_req", LW'(o_req_ready), LW'(0));
    miss_req(34'h0_0000_2060, mk(8'h62), 0, 0, 1'b0);

    // flush in IDLE wins over a simultaneous request
    exp_q.push_back(mk(8'h77));
    i_inv_all = 1'b1; i_req_valid = 1'b1; i_req_pa = 34'h0_0000_2060;
    #1;
    check("flush_blocks_req", LW'(o_req_ready), LW'(0));
    @(negedge clk);
    i_inv_all = 1'b0;
    #1;
    check("req_ready_after_flush", LW'(o_req_ready), LW'(1));
    @(negedge clk);
    i_req_valid = 1'b0;
    serve_miss(34'h0_0000_2060, mk(8'h77), 0, 1'b0);
    get_resp(0);
    exp_miss++;
    check_cnt();

    // reset while in MISS_REQ, then a stray L2 response
    do_req(34'h0_0000_3000);
    @(negedge clk);
    check("rst_test_in_miss", LW'(o_l2_req_valid), LW'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", LW'(o_req_ready), LW'(0));
    check("mid_rst_l2_valid", LW'(o_l2_req_valid), LW'(0));
    rst = 1'b0;
    i_l2_resp_data  = mk(8'hEE);
    i_l2_resp_valid = 1'b1;
    @(negedge clk);
    i_l2_resp_valid = 1'b0;
    i_l2_resp_data  = '0;
    check("post_rst_resp_valid", LW'(o_resp_valid), LW'(0));
    check("post_rst_l2_valid", LW'(o_l2_req_valid), LW'(0));
    check("post_rst_resp_data", o_resp_data, LW'(0));
    check("post_rst_l2_addr", LW'(o_l2_req_addr), LW'(0));
    check("post_rst_req_ready", LW'(o_req_ready), LW'(1));
    exp_hit  = 0;
    exp_miss = 0;
    check_cnt();
    miss_req(34'h0_0000_3000, mk(8'h3C), 0, 0, 1'b0);
    check_cnt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
